// File: rtl/iceif_read_master.sv
// iceif_read_master: initiator on the ICE register bus.
// Accepts single or burst read requests, drives ICEIFA, waits a fixed
// settle time, samples the combinational ICEDO return and hands each word
// out on a valid/ready response port.
module iceif_read_master #(
    parameter int WAIT_CYC  = 2,   // ICEIFA-stable cycles before ICEDO is sampled (1..15)
    parameter int ADDR_STEP = 4    // byte increment between burst beats
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        REQ_VALID,
    output logic        REQ_READY,
    input  logic [31:0] REQ_ADDR,
    input  logic [3:0]  REQ_LEN,
    output logic [31:0] ICEIFA,
    input  logic [31:0] ICEDO,
    output logic        RSP_VALID,
    input  logic        RSP_READY,
    output logic [31:0] RSP_DATA,
    output logic        RSP_LAST,
    output logic        BUSY
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        RESP = 2'd2
    } state_t;

    // Wait counter counts down to zero; the sample happens on the zero cycle,
    // so loading WAIT_CYC-1 gives exactly WAIT_CYC cycles of stable address.
    localparam logic [3:0]  WAIT_LOAD = 4'(WAIT_CYC - 1);
    localparam logic [31:0] STEP      = 32'(ADDR_STEP);

    state_t      state;
    state_t      state_nxt;
    logic [3:0]  wait_cnt;
    logic [3:0]  beat_cnt;
    logic        accept;
    logic        sample;
    logic        rsp_fire;

    // State register; reset forces IDLE at once, without waiting for a clock.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode plus the per-cycle events that steer the datapath.
    always_comb begin
        state_nxt = state;
        REQ_READY = 1'b0;
        BUSY      = 1'b1;
        accept    = 1'b0;
        sample    = 1'b0;
        rsp_fire  = 1'b0;
        case (state)
            IDLE: begin
                REQ_READY = 1'b1;
                BUSY      = 1'b0;
                if (REQ_VALID) begin
                    accept    = 1'b1;
                    state_nxt = ADDR;
                end
            end
            ADDR: begin
                if (wait_cnt == 4'd0) begin
                    sample    = 1'b1;
                    state_nxt = RESP;
                end
            end
            RESP: begin
                if (RSP_VALID && RSP_READY) begin
                    rsp_fire  = 1'b1;
                    state_nxt = RSP_LAST ? IDLE : ADDR;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Bus address: loaded on accept, stepped on a non-final handshake,
    // parked at 0 (no responder selected) after the final handshake.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            ICEIFA <= 32'h0000_0000;
        end else if (accept) begin
            ICEIFA <= REQ_ADDR;
        end else if (rsp_fire) begin
            if (RSP_LAST) begin
                ICEIFA <= 32'h0000_0000;
            end else begin
                ICEIFA <= ICEIFA + STEP;   // wraps modulo 2^32
            end
        end
    end

    // Settle-time and remaining-beat counters.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            wait_cnt <= 4'd0;
            beat_cnt <= 4'd0;
        end else if (accept) begin
            wait_cnt <= WAIT_LOAD;
            beat_cnt <= REQ_LEN;
        end else if (rsp_fire) begin
            wait_cnt <= WAIT_LOAD;
            beat_cnt <= beat_cnt - 4'd1;
        end else if (state == ADDR && !sample) begin
            wait_cnt <= wait_cnt - 4'd1;
        end
    end

    // Response holding register: captured at the sample edge, held under
    // backpressure, released by the handshake.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            RSP_VALID <= 1'b0;
            RSP_DATA  <= 32'h0000_0000;
            RSP_LAST  <= 1'b0;
        end else if (sample) begin
            RSP_VALID <= 1'b1;
            RSP_DATA  <= ICEDO;
            RSP_LAST  <= (beat_cnt == 4'd0);
        end else if (rsp_fire) begin
            RSP_VALID <= 1'b0;
        end
    end

endmodule

// File: doc/iceif_read_master.md
# iceif_read_master

Initiator side of the ICE interface register bus. Accepts single or burst read requests from the host-side control logic and drives the 32-bit address bus ICEIFA. After a fixed settle time it samples the 32-bit read-data bus ICEDO, which every register-block responder returns combinationally from ICEIFA. Each sampled word is returned on a valid/ready response port. The block sits between the host command decoder and the OR'ed ICEDO return path of the responders, such as the ID/version and FNAVAIL registers.

## Interface
Parameters:
- WAIT_CYC, 2, ICEIFA-stable cycles before ICEDO is sampled; legal range 1..15.
- ADDR_STEP, 4, byte increment between burst beats.

Ports:
- CLK  in  1  single clock; all state changes on rising edge.
- RESET  in  1  asynchronous, active-high reset.
- REQ_VALID  in  1  read request present.
- REQ_READY  out  1  block can accept a request.
- REQ_ADDR  in  32  start byte address.
- REQ_LEN  in  4  beats minus one (0 = single read, 15 = 16 beats).
- ICEIFA  out  32  address to responders; registered.
- ICEDO  in  32  read data from responders; combinational function of ICEIFA.
- RSP_VALID  out  1  response word held.
- RSP_READY  in  1  consumer takes word.
- RSP_DATA  out  32  sampled ICEDO; registered.
- RSP_LAST  out  1  final beat of the current request.
- BUSY  out  1  high in any state other than IDLE.

## Operation
- States: IDLE, ADDR, RESP.
- IDLE:
  - REQ_READY=1; ICEIFA driven 32'h0000_0000. Address 0 selects no responder, so ICEDO=0.
  - On REQ_VALID&REQ_READY: latch REQ_ADDR into ICEIFA, REQ_LEN into the beat counter, load the wait counter with WAIT_CYC-1, go to ADDR.
- ADDR:
  - ICEIFA held constant; wait counter decrements each cycle.
  - At the edge where the counter reads 0: RSP_DATA<=ICEDO, RSP_VALID<=1, RSP_LAST<=(beat counter==0), go to RESP.
- RESP:
  - RSP_DATA, RSP_LAST and ICEIFA held stable while RSP_VALID=1 and RSP_READY=0. There is no timeout; backpressure can last indefinitely.
  - On RSP_VALID&RSP_READY with RSP_LAST=1: RSP_VALID<=0, ICEIFA<=0, go to IDLE.
  - On RSP_VALID&RSP_READY with RSP_LAST=0: RSP_VALID<=0, ICEIFA<=ICEIFA+ADDR_STEP, beat counter decrements, wait counter reloads, go to ADDR.
- Address arithmetic is 32-bit modulo 2^32; carries out of bit 31 are dropped. No alignment check is made, and low address bits pass through unchanged.
- REQ_READY=0 outside IDLE. REQ_VALID outside IDLE is ignored and is not queued.
- REQ_ADDR and REQ_LEN are sampled only at the accept edge; later changes have no effect.
- RESET asserted at any time, including mid-burst:
  - State goes to IDLE immediately and asynchronously.
  - All outputs go to reset values; no partial or late response is produced after release.
  - A response that was pending is dropped.
- Reset values: REQ_READY=1 (combinational from IDLE), ICEIFA=0, RSP_VALID=0, RSP_DATA=0, RSP_LAST=0, BUSY=0.

## Timing
- Accept at edge k: ICEIFA carries the new address from edge k.
- ICEDO is sampled at edge k+WAIT_CYC; RSP_VALID is high from edge k+WAIT_CYC.
- Default single-read latency (accept edge to RSP_VALID edge) is 2 cycles.
- Burst:
  - A response handshake at edge m moves ICEIFA to the next address at edge m.
  - The next sample is taken at edge m+WAIT_CYC.
  - With RSP_READY held high, a beat completes every WAIT_CYC+1 cycles; the default is 3.
- Earliest next accept after the last handshake: the cycle following that handshake edge, once state is IDLE and REQ_READY=1.
- ICEIFA never changes during ADDR or while RSP_VALID=1.
- BUSY is high from the accept edge through the final handshake edge.

## Test plan
- **Single ID read:** responder model maps 0880_8xxxH to IDVER=32'h0107_0000. Request addr 32'h0880_8000, len 0 -> ICEIFA=0880_8000 for 2 cycles; RSP_DATA=32'h0107_0000, RSP_LAST=1, RSP_VALID 2 cycles after accept; ICEIFA returns to 0 after the handshake.
- **Burst across FNAVAIL:** request addr 32'h0880_4000, len 3 -> ICEIFA steps 4000, 4004, 4008, 400C; RSP_DATA=0, 0, 32'h0000_0003, 0; RSP_LAST only on beat 4; with RSP_READY held high, beats are 3 cycles apart.
- **Backpressure:** len 1 at 32'h0880_8000, RSP_READY low for 10 cycles -> RSP_VALID, RSP_DATA and ICEIFA stable throughout; no second address until the handshake. A REQ_VALID pulse during the burst is ignored (REQ_READY=0).
- **Address wrap:** addr 32'hFFFF_FFFC, len 1 -> ICEIFA=FFFF_FFFC then 32'h0000_0000; both responses equal 0.
- **Reset mid-burst:** RESET asserted in ADDR of beat 2 of a len-3 burst -> ICEIFA=0, RSP_VALID=0, BUSY=0 and REQ_READY=1 without waiting for a clock edge; no response after release; a fresh request then completes normally.
- **WAIT_CYC=1 instance:** single read at 0880_8000 -> RSP_VALID 1 cycle after accept with the correct data.
